// File: rtl/mel_frame_energy_if.sv
// Stream bundle for the mel frame-energy block: per-band sample input plus the
// compressed-energy output stream and its sticky status flags.
interface mel_frame_energy_if #(
  parameter int NUM_BANDS = 15
);
  // A beat transfers on any rising clk where out_valid && out_ready; while
  // out_valid is high and out_ready low, out_energy/out_band/out_last hold.
  logic [NUM_BANDS-1:0][15:0] band_in;
  logic [NUM_BANDS-1:0]       valid_bus;
  logic                       clear;
  logic [15:0]                out_energy;
  logic [3:0]                 out_band;
  logic                       out_valid;
  logic                       out_last;
  logic                       out_ready;
  logic                       overrun;
  logic                       skew_err;

  modport master (
    output band_in, valid_bus, clear, out_ready,
    input  out_energy, out_band, out_valid, out_last, overrun, skew_err
  );

  modport slave (
    input  band_in, valid_bus, clear, out_ready,
    output out_energy, out_band, out_valid, out_last, overrun, skew_err
  );
endinterface

// File: rtl/mel_frame_energy.sv
// Per-band squared-sample accumulation over a frame, snapshot at frame end and
// log2-compressed drain of one band per beat to the classifier.
module mel_frame_energy #(
  parameter int NUM_BANDS = 15,
  parameter int FRAME_LEN = 256,
  parameter int ACC_W     = 40
) (
  input  logic              clk,
  input  logic              rst,
  mel_frame_energy_if.slave bus,
  output logic [1:0]        state_dbg
);
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [3:0]       BAND_LAST = 4'(NUM_BANDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q    [NUM_BANDS];
  logic [ACC_W-1:0]  acc_d    [NUM_BANDS];
  logic [ACC_W-1:0]  acc_next [NUM_BANDS];
  logic [ACC_W-1:0]  shadow_q [NUM_BANDS];
  logic [ACC_W-1:0]  shadow_d [NUM_BANDS];
  logic signed [31:0] band_x  [NUM_BANDS];
  logic [31:0]       band_sq  [NUM_BANDS];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       out_energy_q, out_energy_d;
  logic [3:0]        out_band_q, out_band_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              overrun_q, overrun_d;
  logic              skew_err_q, skew_err_d;

  logic              accept, frame_end, fire, last_beat;
  logic [3:0]        next_band, sel_band;
  logic [ACC_W-1:0]  sel_shadow;
  logic [15:0]       sel_cmp;

  // {exp = leading-one index, 10 bits below the leading one, left-aligned}
  function automatic logic [15:0] cmp(input logic [ACC_W-1:0] x);
    logic [5:0]       p;
    logic [ACC_W-1:0] sh;
    p = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (x[i]) p = 6'(i);
    end
    sh  = x << (ACC_W - 1 - int'(p));
    cmp = (x == '0) ? 16'h0000 : {p, sh[ACC_W-2 -: 10]};
  endfunction

  assign accept    = (&bus.valid_bus) && !bus.clear;
  assign frame_end = accept && (cnt_q == CNT_LAST);
  assign fire      = out_valid_q && bus.out_ready;
  assign last_beat = (out_band_q == BAND_LAST);
  assign next_band = out_band_q + 4'd1;
  assign sel_band  = (state_q == LOAD) ? 4'd0 : next_band;

  always_comb begin
    sel_shadow = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      band_x[b]   = {{16{bus.band_in[b][15]}}, bus.band_in[b]};
      band_sq[b]  = band_x[b] * band_x[b];
      acc_next[b] = acc_q[b] + {{(ACC_W-32){1'b0}}, band_sq[b]};
      if (sel_band == 4'(b)) sel_shadow = shadow_q[b];
    end
    sel_cmp = cmp(sel_shadow);
  end

  // Accumulators keep running while a previous frame drains from the shadow bank.
  always_comb begin
    cnt_d      = cnt_q;
    overrun_d  = overrun_q;
    skew_err_d = skew_err_q;
    for (int b = 0; b < NUM_BANDS; b++) begin
      acc_d[b]    = acc_q[b];
      shadow_d[b] = shadow_q[b];
    end
    if (bus.clear) begin
      cnt_d      = '0;
      overrun_d  = 1'b0;
      skew_err_d = 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) acc_d[b] = '0;
    end else if (accept) begin
      if (frame_end) begin
        cnt_d = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
          acc_d[b] = '0;
          if (state_q == IDLE) shadow_d[b] = acc_next[b];
        end
        if (state_q != IDLE) overrun_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        for (int b = 0; b < NUM_BANDS; b++) acc_d[b] = acc_next[b];
      end
    end else if (|bus.valid_bus) begin
      skew_err_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_end) state_d = LOAD;
      LOAD:    state_d = DRAIN;
      DRAIN:   if (fire && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_energy_d = out_energy_q;
    out_band_d   = out_band_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    case (state_q)
      LOAD: begin
        out_energy_d = sel_cmp;
        out_band_d   = 4'd0;
        out_valid_d  = 1'b1;
        out_last_d   = (NUM_BANDS == 1);
      end
      DRAIN: begin
        if (fire) begin
          if (last_beat) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            out_band_d   = next_band;
            out_energy_d = sel_cmp;
            out_last_d   = (next_band == BAND_LAST);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      out_energy_q <= '0;
      out_band_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      overrun_q    <= 1'b0;
      skew_err_q   <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        acc_q[b]    <= '0;
        shadow_q[b] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_energy_q <= out_energy_d;
      out_band_q   <= out_band_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      overrun_q    <= overrun_d;
      skew_err_q   <= skew_err_d;
      for (int b = 0; b < NUM_BANDS; b++) begin
        acc_q[b]    <= acc_d[b];
        shadow_q[b] <= shadow_d[b];
      end
    end
  end

  assign bus.out_energy = out_energy_q;
  assign bus.out_band   = out_band_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.overrun    = overrun_q;
  assign bus.skew_err   = skew_err_q;
  assign state_dbg      = state_q;
endmodule

// File: tb/tb_mel_frame_energy.sv
// Bench for mel_frame_energy with a short frame: directed scenarios plus random
// traffic, scored against a frame-level reference model.
module tb_mel_frame_energy;
  localparam int NB = 15;
  localparam int FL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  mel_frame_energy_if #(.NUM_BANDS(NB)) bus ();

  mel_frame_energy #(.NUM_BANDS(NB), .FRAME_LEN(FL), .ACC_W(40)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries: {last, band[3:0], energy[15:0]}
  logic [20:0]     exp_q[$];
  longint unsigned m_acc[NB];
  int              m_cnt;
  bit              m_busy;
  int              m_dly;
  bit              m_ovr;
  bit              m_skew;

  logic [14:0] drv_vb;
  logic [15:0] drv_band[NB];
  logic        drv_clr;
  logic        drv_rdy;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // floor(log2(x)) and the fractional part scaled to 10 bits
  function automatic logic [15:0] ref_cmp(input longint unsigned x);
    longint unsigned t, frac, mant;
    int p;
    if (x < 2) return 16'h0000;
    p = 0;
    t = x;
    while (t > 1) begin
      t = t / 2;
      p++;
    end
    frac = x - (64'd1 << p);
    mant = (frac * 1024) >> p;
    return {6'(p), 10'(mant)};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int b = 0; b < NB; b++) m_acc[b] = 0;
    m_cnt  = 0;
    m_busy = 0;
    m_dly  = 0;
    m_ovr  = 0;
    m_skew = 0;
  endtask

  // One clock: check outputs at the falling edge, drive inputs, advance the model.
  task automatic cycle();
    bit exp_valid, hs, old_busy;
    int v;
    @(negedge clk);
    exp_valid = m_busy && (m_dly == 0);
    check_eq("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    if (exp_valid && exp_q.size() > 0)
      check_eq("beat", 32'({bus.out_last, bus.out_band, bus.out_energy}), 32'(exp_q[0]));
    check_eq("overrun", 32'(bus.overrun), 32'(m_ovr));
    check_eq("skew_err", 32'(bus.skew_err), 32'(m_skew));

    bus.valid_bus = drv_vb;
    for (int b = 0; b < NB; b++) bus.band_in[b] = drv_band[b];
    bus.clear     = drv_clr;
    bus.out_ready = drv_rdy;

    hs       = exp_valid && drv_rdy;
    old_busy = m_busy;
    if (m_busy && m_dly > 0) m_dly--;
    else if (hs) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) m_busy = 0;
    end

    if (drv_clr) begin
      for (int b = 0; b < NB; b++) m_acc[b] = 0;
      m_cnt  = 0;
      m_ovr  = 0;
      m_skew = 0;
    end else if (&drv_vb) begin
      for (int b = 0; b < NB; b++) begin
        v = int'($signed(drv_band[b]));
        m_acc[b] += longint'(v * v);
      end
      if (m_cnt == FL - 1) begin
        m_cnt = 0;
        if (!old_busy) begin
          for (int b = 0; b < NB; b++)
            exp_q.push_back({(b == NB - 1), 4'(b), ref_cmp(m_acc[b])});
          m_busy = 1;
          m_dly  = 1;
        end else begin
          m_ovr = 1;
        end
        for (int b = 0; b < NB; b++) m_acc[b] = 0;
      end else begin
        m_cnt++;
      end
    end else if (drv_vb != '0) begin
      m_skew = 1;
    end
  endtask

  task automatic set_all(input logic [15:0] val);
    for (int b = 0; b < NB; b++) drv_band[b] = val;
  endtask

  task automatic set_rand();
    for (int b = 0; b < NB; b++) drv_band[b] = 16'($urandom);
  endtask

  task automatic accepts(input int n);
    drv_vb = '1;
    repeat (n) cycle();
    drv_vb = '0;
  endtask

  task automatic drain();
    drv_rdy = 1'b1;
    drv_vb  = '0;
    for (int i = 0; i < 60 && m_busy; i++) cycle();
    cycle();
    check_eq("drain_idle", 32'(state_dbg), 32'(0));
  endtask

  task automatic pulse_clear();
    drv_clr = 1'b1;
    cycle();
    drv_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [20:0] f;
    int          k;
    drv_vb  = '0;
    drv_clr = 1'b0;
    drv_rdy = 1'b1;
    set_all(16'h0);
    bus.valid_bus = '0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    for (int b = 0; b < NB; b++) bus.band_in[b] = '0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("rst_out_band", 32'(bus.out_band), 32'(0));
    check_eq("rst_out_energy", 32'(bus.out_energy), 32'(0));
    check_eq("rst_out_last", 32'(bus.out_last), 32'(0));
    check_eq("rst_overrun", 32'(bus.overrun), 32'(0));
    check_eq("rst_skew_err", 32'(bus.skew_err), 32'(0));
    check_eq("rst_state", 32'(state_dbg), 32'(0));
    rst = 1'b1;

    // All bands 1024: every band reaches 2^22
    set_all(16'd1024);
    accepts(FL);
    drain();

    // Single negative sample on band 0
    set_all(16'h0);
    drv_band[0] = 16'hFFFD;
    accepts(FL);
    drain();

    // Stall 5 cycles after first valid, then toggle ready
    set_rand();
    drv_rdy = 1'b0;
    accepts(FL);
    for (int i = 0; i < 10 && !(m_busy && m_dly == 0); i++) cycle();
    repeat (5) cycle();
    k = 0;
    for (int i = 0; i < 100 && m_busy; i++) begin
      drv_rdy = (k % 2 == 0);
      k++;
      cycle();
    end
    drain();

    // Two whole frames while stalled: second frame is lost
    drv_rdy = 1'b0;
    set_rand();
    accepts(FL);
    set_rand();
    accepts(FL);
    repeat (3) cycle();
    drain();
    pulse_clear();

    // Partial valid_bus then a full frame
    set_rand();
    drv_vb = 15'h7FFE;
    repeat (3) cycle();
    accepts(FL);
    drain();
    pulse_clear();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      k = int'($urandom_range(0, 9));
      if (k < 6) drv_vb = '1;
      else if (k < 8) drv_vb = '0;
      else begin
        drv_vb = 15'($urandom);
        if (drv_vb == '0 || &drv_vb) drv_vb = 15'h0001;
      end
      if ($urandom_range(0, 1) == 0) set_rand();
      else for (int b = 0; b < NB; b++) drv_band[b] = 16'($signed(int'($urandom_range(0, 64)) - 32));
      drv_clr = ($urandom_range(0, 39) == 0);
      drv_rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drv_clr = 1'b0;
    drain();
    pulse_clear();

    // Asynchronous reset in the middle of a drain
    set_rand();
    drv_rdy = 1'b1;
    accepts(FL);
    drv_vb = '1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (m_busy && m_dly == 0 && exp_q.size() > 0) begin
        f = exp_q[0];
        if (f[19:16] == 4'd7) break;
      end
    end
    @(posedge clk);
    #2;
    check_eq("pre_rst_band", 32'(bus.out_band), 32'(7));
    rst = 1'b0;
    #1;
    check_eq("async_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("async_out_band", 32'(bus.out_band), 32'(0));
    check_eq("async_out_energy", 32'(bus.out_energy), 32'(0));
    check_eq("async_out_last", 32'(bus.out_last), 32'(0));
    model_reset();
    drv_vb = '0;
    bus.valid_bus = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_rand();
    accepts(FL - 1);
    repeat (3) cycle();
    accepts(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
